// File: rtl/snn_out_pkg.sv
// Shared sizing and state encoding for the output-layer sequencer.
package snn_out_pkg;

   localparam int NUM_HID = 32;
   localparam int NUM_OUT = 10;
   localparam int ACC_W   = 22;

   localparam int HID_AW  = $clog2(NUM_HID);
   localparam int W_AW    = $clog2(NUM_HID * NUM_OUT);
   localparam int OUT_AW  = $clog2(NUM_OUT);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      DRAIN,
      WRITE,
      FIN
   } state_t;

endpackage

// File: rtl/out_mac_acc.sv
// Signed multiply-accumulate for one output neuron: unsigned activation
// times signed weight, summed into an ACC_W-bit signed accumulator.
module out_mac_acc
   import snn_out_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     en,
   input  logic [DATA_W-1:0]        act,
   input  logic signed [COEF_W-1:0] coef,
   output logic signed [ACC_W-1:0]  acc,
   output logic signed [ACC_W-1:0]  acc_sum
);

   localparam int PROD_W = DATA_W + COEF_W + 1;

   logic signed [DATA_W:0]   act_s;
   logic signed [PROD_W-1:0] prod_p1;
   logic signed [ACC_W-1:0]  prod_ext;

   // Zero-extend the activation so it multiplies as a non-negative signed value.
   always_comb begin
      act_s    = signed'({1'b0, act});
      prod_p1  = PROD_W'(act_s) * PROD_W'(coef);
      prod_ext = {{(ACC_W - PROD_W){prod_p1[PROD_W-1]}}, prod_p1};
      acc_sum  = acc + prod_ext;
   end

   // Accumulator: clear wins over enable so a new neuron always starts at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc_sum;
   end

endmodule

// File: rtl/output_layer_mac.sv
// Output-layer sequencer: walks the 10x32 weight ROM and hidden RAM, forms
// each output neuron's sum, writes the rectified/scaled byte and reports the
// argmax digit. Build option OUTPUT_LAYER_MAC_SAT_EN clamps the scaled
// output at 255 instead of keeping its low byte.
module output_layer_mac
   import snn_out_pkg::*;
#(
   parameter int SHIFT  = 7,
   parameter int DATA_W = 8,
   parameter int COEF_W = 8
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic [HID_AW-1:0]        hid_addr,
   input  logic [DATA_W-1:0]        hid_q,
   output logic [W_AW-1:0]          w_addr,
   input  logic signed [COEF_W-1:0] w_q,
   output logic                     out_we,
   output logic [OUT_AW-1:0]        out_addr,
   output logic [7:0]               out_data,
   output logic [OUT_AW-1:0]        digit,
   output logic                     busy,
   output logic                     done
);

   localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(255);

   state_t                   state;
   state_t                   state_nxt;
   logic [OUT_AW-1:0]        neuron;
   logic                     vld_p0;
   logic                     vld_p1;
   logic                     mac_clr;
   logic                     last_hid;
   logic                     last_out;
   logic                     take;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_sum;
   logic signed [ACC_W-1:0]  best_acc;
   logic [OUT_AW-1:0]        best_idx;

   // Negative sums rectify to zero; positive sums are shifted down to a byte.
   function automatic logic [7:0] scale_out(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] sh;
      sh = a >>> SHIFT;
      if (a[ACC_W-1])
         return 8'd0;
`ifdef OUTPUT_LAYER_MAC_SAT_EN
      if (sh > OUT_MAX)
         return 8'hFF;
`endif
      return 8'(sh);
   endfunction

   assign last_hid = (hid_addr == HID_AW'(NUM_HID - 1));
   assign last_out = (neuron == OUT_AW'(NUM_OUT - 1));
   // Neuron 0 seeds the best score; later neurons must be strictly greater.
   assign take     = (neuron == '0) || (acc > best_acc);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and per-cycle strobes decoded from the current state.
   always_comb begin
      state_nxt = state;
      vld_p0    = 1'b0;
      mac_clr   = 1'b0;
      case (state)
         IDLE: begin
            mac_clr = 1'b1;
            if (start)
               state_nxt = ISSUE;
         end
         ISSUE: begin
            vld_p0 = 1'b1;
            if (last_hid)
               state_nxt = DRAIN;
         end
         DRAIN: state_nxt = WRITE;
         WRITE: begin
            mac_clr   = 1'b1;
            state_nxt = last_out ? FIN : ISSUE;
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Read addresses: the weight address runs 0..319 without gaps because each
   // neuron's block follows the previous one, and the 5-bit hidden index wraps
   // from 31 back to 0 on its own. Both hold outside ISSUE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hid_addr <= '0;
         w_addr   <= '0;
      end else if (state_nxt == ISSUE) begin
         if (state == IDLE) begin
            hid_addr <= '0;
            w_addr   <= '0;
         end else begin
            hid_addr <= hid_addr + HID_AW'(1);
            w_addr   <= w_addr + W_AW'(1);
         end
      end
   end

   // Output-neuron counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         neuron <= '0;
      else if ((state == IDLE) && start)
         neuron <= '0;
      else if ((state == WRITE) && !last_out)
         neuron <= neuron + OUT_AW'(1);
   end

   // ---- stage p0 -> p1: memories return the issued pair one cycle later ----
   // Control strobes: read-valid pipe, busy, done and the write strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         out_we <= 1'b0;
      end else begin
         vld_p1 <= vld_p0;
         busy   <= (state_nxt == ISSUE) || (state_nxt == DRAIN) ||
                   (state_nxt == WRITE);
         done   <= (state == WRITE) && last_out;
         out_we <= (state == DRAIN);
      end
   end

   out_mac_acc #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W)
   ) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (mac_clr),
      .en      (vld_p1),
      .act     (hid_q),
      .coef    (w_q),
      .acc     (acc),
      .acc_sum (acc_sum)
   );

   // ---- stage p1 -> write: final sum leaves DRAIN, scored during WRITE ----
   // Result byte is captured from the sum that includes the last product;
   // argmax is updated from the settled accumulator during WRITE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_addr <= '0;
         out_data <= '0;
         best_acc <= '0;
         best_idx <= '0;
         digit    <= '0;
      end else begin
         if (state == DRAIN) begin
            out_addr <= neuron;
            out_data <= scale_out(acc_sum);
         end
         if (state == WRITE) begin
            if (take) begin
               best_acc <= acc;
               best_idx <= neuron;
            end
            if (last_out)
               digit <= take ? neuron : best_idx;
         end
      end
   end

endmodule

// File: tb/tb_output_layer_mac.sv
// Bench for output_layer_mac: two instances (SHIFT=0 and SHIFT=7) share the
// stimulus; a behavioural model of the neuron sums predicts every output.
module tb_output_layer_mac;

`ifdef OUTPUT_LAYER_MAC_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;

   logic [4:0]        hid_addr0, hid_addr7;
   logic [8:0]        w_addr0, w_addr7;
   logic [7:0]        hid_q0, hid_q7;
   logic signed [7:0] w_q0, w_q7;
   logic              out_we0, out_we7;
   logic [3:0]        out_addr0, out_addr7;
   logic [7:0]        out_data0, out_data7;
   logic [3:0]        digit0, digit7;
   logic              busy0, busy7;
   logic              done0, done7;

   logic [7:0]        hid_mem [32];
   logic signed [7:0] w_mem [512];

   int acc_m [10];
   int exp0 [10];
   int exp7 [10];
   int exp_digit;
   int got0 [10];
   int got7 [10];
   int we_cnt;
   int done_cnt;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit run = 1'b0;

   always #5 clk = ~clk;

   output_layer_mac #(.SHIFT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .hid_addr(hid_addr0), .hid_q(hid_q0), .w_addr(w_addr0), .w_q(w_q0),
      .out_we(out_we0), .out_addr(out_addr0), .out_data(out_data0),
      .digit(digit0), .busy(busy0), .done(done0)
   );

   output_layer_mac #(.SHIFT(7)) u_dut7 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .hid_addr(hid_addr7), .hid_q(hid_q7), .w_addr(w_addr7), .w_q(w_q7),
      .out_we(out_we7), .out_addr(out_addr7), .out_data(out_data7),
      .digit(digit7), .busy(busy7), .done(done7)
   );

   // Registered-read memories, one read port per instance.
   always @(posedge clk) begin
      hid_q0 <= hid_mem[hid_addr0];
      w_q0   <= w_mem[w_addr0];
      hid_q7 <= hid_mem[hid_addr7];
      w_q7   <= w_mem[w_addr7];
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int scale(input int s, input int sh);
      int v;
      if (s < 0) return 0;
      v = s / (1 << sh);
      if (SAT) return (v > 255) ? 255 : v;
      return v % 256;
   endfunction

   task automatic compute_model();
      int best;
      for (int n = 0; n < 10; n++) begin
         int s;
         s = 0;
         for (int i = 0; i < 32; i++)
            s += int'(hid_mem[i]) * int'(w_mem[n*32 + i]);
         acc_m[n] = s;
         exp0[n]  = scale(s, 0);
         exp7[n]  = scale(s, 7);
      end
      best = 0;
      for (int n = 1; n < 10; n++)
         if (acc_m[n] > acc_m[best]) best = n;
      exp_digit = best;
   endtask

   // Compare process: cycle-by-cycle against the pass timeline of the model.
   always @(negedge clk) begin : cmp
      int n;
      int j;
      bit in_pass;
      bit exp_we;
      if (!rst_n) begin
         run = 1'b0;
         chk("rst_we0", out_we0, 0);
         chk("rst_we7", out_we7, 0);
      end else begin
         if (run)
            cyc++;
         else if (start) begin
            run = 1'b1;
            cyc = 0;
            we_cnt = 0;
            done_cnt = 0;
            compute_model();
         end
         if (run) begin
            in_pass = (cyc >= 1) && (cyc <= 340);
            n = 0;
            j = 0;
            if (in_pass) begin
               n = (cyc - 1) / 34;
               j = (cyc - 1) % 34;
            end
            exp_we = in_pass && (j == 33);
            chk("busy0", busy0, int'(in_pass));
            chk("busy7", busy7, int'(in_pass));
            chk("done0", done0, int'(cyc == 341));
            chk("done7", done7, int'(cyc == 341));
            chk("out_we0", out_we0, int'(exp_we));
            chk("out_we7", out_we7, int'(exp_we));
            if (done0) done_cnt++;
            if (in_pass && (j < 32)) begin
               chk("w_addr0", w_addr0, n*32 + j);
               chk("hid_addr0", hid_addr0, j);
               chk("w_addr7", w_addr7, n*32 + j);
               chk("hid_addr7", hid_addr7, j);
            end
            if (exp_we) begin
               chk("out_addr0", out_addr0, n);
               chk("out_data0", out_data0, exp0[n]);
               chk("out_addr7", out_addr7, n);
               chk("out_data7", out_data7, exp7[n]);
               got0[n] = out_data0;
               got7[n] = out_data7;
               we_cnt++;
            end
            if (cyc == 341) begin
               chk("digit0", digit0, exp_digit);
               chk("digit7", digit7, exp_digit);
               run = 1'b0;
            end
         end else begin
            chk("idle_we0", out_we0, 0);
            chk("idle_done0", done0, 0);
            chk("idle_busy0", busy0, 0);
         end
      end
   end

   task automatic fill(input int mode);
      for (int a = 0; a < 512; a++) w_mem[a] = 8'sd0;
      for (int i = 0; i < 32; i++) begin
         case (mode)
            1: hid_mem[i] = 8'd1;
            2: hid_mem[i] = 8'd255;
            3: hid_mem[i] = 8'd10;
            4: hid_mem[i] = 8'((i*37 + 11) % 256);
            default: hid_mem[i] = 8'd0;
         endcase
         for (int n = 0; n < 10; n++) begin
            case (mode)
               1: w_mem[n*32 + i] = 8'sd1;
               2: w_mem[n*32 + i] = (n == 7) ? 8'sd127 : 8'sd0;
               3: w_mem[n*32 + i] = -8'sd1;
               4: w_mem[n*32 + i] = 8'(((n*13 + i*7) % 41) - 20);
               default: w_mem[n*32 + i] = 8'sd0;
            endcase
         end
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      for (k = 0; k < 400; k++) begin
         @(negedge clk);
         if (done0 && done7) break;
      end
      checks++;
      if (k >= 400) begin
         errors++;
         $display("FAIL done_timeout: no done within %0d cycles", k);
      end
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_hid_addr0"}, hid_addr0, 0);
      chk({tag, "_w_addr0"}, w_addr0, 0);
      chk({tag, "_out_addr0"}, out_addr0, 0);
      chk({tag, "_out_data0"}, out_data0, 0);
      chk({tag, "_digit0"}, digit0, 0);
      chk({tag, "_out_we0"}, out_we0, 0);
      chk({tag, "_busy0"}, busy0, 0);
      chk({tag, "_done0"}, done0, 0);
      chk({tag, "_hid_addr7"}, hid_addr7, 0);
      chk({tag, "_w_addr7"}, w_addr7, 0);
      chk({tag, "_digit7"}, digit7, 0);
      chk({tag, "_busy7"}, busy7, 0);
   endtask

   initial begin
      fill(0);
      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      rst_n = 1'b1;

      // All ones, SHIFT=0 gives 32 everywhere; tie resolves to digit 0.
      fill(1);
      pulse_start();
      wait_done();
      chk("t1_model_acc3", acc_m[3], 32);
      chk("t1_out0_s0", got0[0], 32);
      chk("t1_out9_s0", got0[9], 32);
      chk("t1_out4_s7", got7[4], 0);
      chk("t1_digit", digit0, 0);
      chk("t1_we_cnt", we_cnt, 10);

      // Only neuron 7 is driven: 255*127*32 = 1036320, >>7 = 8096.
      fill(2);
      pulse_start();
      wait_done();
      chk("t2_model_acc7", acc_m[7], 1036320);
      chk("t2_out7_s7", got7[7], SAT ? 255 : 160);
      chk("t2_out7_s0", got0[7], SAT ? 255 : 32);
      chk("t2_out6_s7", got7[6], 0);
      chk("t2_digit0", digit0, 7);
      chk("t2_digit7", digit7, 7);

      // Reset around cycle 100 of a pass: outputs clear without a clock edge.
      pulse_start();
      repeat (99) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk_zero("midrst");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      pulse_start();
      wait_done();
      chk("t3_out7_s7", got7[7], SAT ? 255 : 160);
      chk("t3_digit7", digit7, 7);
      chk("t3_we_cnt", we_cnt, 10);

      // All weights -1: every sum is -320, rectified to 0, digit 0.
      fill(3);
      pulse_start();
      wait_done();
      chk("t4_model_acc0", acc_m[0], -320);
      chk("t4_out5_s0", got0[5], 0);
      chk("t4_out9_s7", got7[9], 0);
      chk("t4_digit", digit0, 0);
      chk("t4_we_cnt", we_cnt, 10);

      // Mixed-sign data with start re-pulsed mid-pass.
      fill(4);
      pulse_start();
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (194) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done();
      chk("t5_we_cnt", we_cnt, 10);
      chk("t5_done_cnt", done_cnt, 1);
      chk("t5_digit", digit7, exp_digit);
      repeat (20) @(posedge clk);
      #1 chk("t5_digit_held", digit0, exp_digit);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
